// File: rtl/sayeh_mem_ctrl_if.sv
// CPU/RAM bus bundle for the Sayeh memory controller.
// The controller takes the slave view; the CPU plus RAM environment takes the master view.
interface sayeh_mem_ctrl_if #(
   parameter int unsigned CPU_AW = 16,
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned DW     = 16
);
   logic              cpu_rd;
   logic              cpu_wr;
   logic [CPU_AW-1:0] cpu_addr;
   logic [DW-1:0]     cpu_wdata;
   logic [DW-1:0]     cpu_rdata;
   logic              cpu_done;
   logic              cpu_err;
   logic              busy;
   logic [MEM_AW-1:0] mem_addr;
   logic [DW-1:0]     mem_din;
   logic              mem_nd;
   logic              mem_we;
   logic [DW-1:0]     mem_dout;
   logic              mem_rdy;

   modport slave (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_dout, mem_rdy,
      output cpu_rdata, cpu_done, cpu_err, busy, mem_addr, mem_din, mem_nd, mem_we
   );

   modport master (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_dout, mem_rdy,
      input  cpu_rdata, cpu_done, cpu_err, busy, mem_addr, mem_din, mem_nd, mem_we
   );
endinterface

// File: rtl/sayeh_mem_ctrl.sv
// Sayeh CPU-to-RAM controller: one word per access, RAM strobes held until rdy,
// bounded wait with timeout, one-cycle done/err pulses. All state on posedge clk.
module sayeh_mem_ctrl #(
   parameter int unsigned CPU_AW  = 16,
   parameter int unsigned MEM_AW  = 10,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input logic            clk,
   input logic            rst_n,
   sayeh_mem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_e;

   state_e     state_q;
   logic       op_wr_q;
   logic [7:0] cnt_q;

   logic addr_ok;
   logic rdy_ok;
   logic timed_out;

   assign addr_ok = (bus.cpu_addr[CPU_AW-1:MEM_AW] == '0);
   // A write's rdy seen in the first WAIT cycle may be stale from the previous write.
   assign rdy_ok    = bus.mem_rdy && (!op_wr_q || (cnt_q != 8'd0));
   assign timed_out = ({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         op_wr_q       <= 1'b0;
         cnt_q         <= 8'd0;
         bus.cpu_rdata <= '0;
         bus.cpu_done  <= 1'b0;
         bus.cpu_err   <= 1'b0;
         bus.busy      <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_din   <= '0;
         bus.mem_nd    <= 1'b0;
         bus.mem_we    <= 1'b0;
      end else begin
         bus.cpu_done <= 1'b0;
         bus.cpu_err  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.cpu_rd || bus.cpu_wr) begin
                  bus.busy <= 1'b1;
                  if ((bus.cpu_rd && bus.cpu_wr) || !addr_ok) begin
                     bus.cpu_err <= 1'b1;
                     state_q     <= StErr;
                  end else begin
                     bus.mem_addr <= bus.cpu_addr[MEM_AW-1:0];
                     bus.mem_din  <= bus.cpu_wdata;
                     op_wr_q      <= bus.cpu_wr;
                     bus.mem_nd   <= bus.cpu_rd;
                     bus.mem_we   <= bus.cpu_wr;
                     state_q      <= StReq;
                  end
               end
            end
            StReq: begin
               cnt_q   <= 8'd0;
               state_q <= StWait;
            end
            StWait: begin
               if (cnt_q != 8'hff) begin
                  cnt_q <= cnt_q + 8'd1;
               end
               if (rdy_ok) begin
                  if (!op_wr_q) begin
                     bus.cpu_rdata <= bus.mem_dout;
                  end
                  bus.mem_nd   <= 1'b0;
                  bus.mem_we   <= 1'b0;
                  bus.cpu_done <= 1'b1;
                  state_q      <= StDone;
               end else if (timed_out) begin
                  bus.mem_nd  <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  bus.cpu_err <= 1'b1;
                  state_q     <= StErr;
               end
            end
            StDone, StErr: begin
               bus.busy <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sayeh_mem_ctrl.sv
// Randomised scoreboard bench for sayeh_mem_ctrl with a negedge RAM model whose
// rdy latency is set per transaction.
module tb_sayeh_mem_ctrl;

   localparam int unsigned TIMEOUT = 15;

   typedef struct {
      bit          is_err;
      logic [15:0] rdata;
      int          edges;
      bit          strobe;
      int          accept;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sayeh_mem_ctrl_if #(.CPU_AW(16), .MEM_AW(10), .DW(16)) bus ();

   sayeh_mem_ctrl #(
      .CPU_AW (16),
      .MEM_AW (10),
      .DW     (16),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [15:0] ram     [1024];
   logic [15:0] ref_mem [1024];
   logic [15:0] last_rdata = 16'h0;
   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ram_delay = 0;
   int          strobe_n = 0;
   bit          strobe_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM: samples strobes on negedge, rdy/dout settle 2 time units later.
   always @(negedge clk) begin : ram_model
      bit          go;
      bit          rd;
      logic [15:0] v;
      go = 0;
      rd = 0;
      v  = 16'h0;
      if (bus.mem_nd || bus.mem_we) begin
         strobe_n++;
         if (strobe_n > ram_delay) begin
            go = 1;
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_din;
            else begin
               rd = 1;
               v  = ram[bus.mem_addr];
            end
         end
      end else begin
         strobe_n = 0;
      end
      #2;
      bus.mem_rdy  = go;
      bus.mem_dout = rd ? v : 16'h0;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.mem_nd || bus.mem_we) strobe_seen = 1;
      if (rst_n && (bus.cpu_done || bus.cpu_err)) begin
         chk("done_err_exclusive", {31'd0, bus.cpu_done & bus.cpu_err}, 32'd0);
         chk("strobes_low_at_end", {30'd0, bus.mem_nd, bus.mem_we}, 32'd0);
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response done=%0b err=%0b expected=none",
                     bus.cpu_done, bus.cpu_err);
         end else begin
            e = expq.pop_front();
            chk("resp_kind_err", {31'd0, bus.cpu_err}, {31'd0, e.is_err});
            chk("resp_latency", 32'(cyc - e.accept + 1), 32'(e.edges));
            chk("resp_rdata", {16'd0, bus.cpu_rdata}, {16'd0, e.rdata});
            chk("strobe_seen", {31'd0, strobe_seen}, {31'd0, e.strobe});
         end
      end
   end

   task automatic set_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      bus.cpu_rd    = rd;
      bus.cpu_wr    = wr;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
   endtask

   // Expected outcome derived from access rules: read completes at the first WAIT
   // edge (edge index >= 2) where rdy is up, writes from edge 3 on; rdy first appears
   // after strobe negedge delay+1, which precedes edge index delay+1.
   task automatic issue(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input int delay, input bit garbage);
      exp_t e;
      bit   bad;
      int   k;
      int   n;
      n = 0;
      while (bus.busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      ram_delay = delay;
      bad       = (rd && wr) || (a[15:10] != 6'd0);
      e.accept  = cyc + 1;
      e.strobe  = !bad;
      if (bad) begin
         e.is_err = 1;
         e.edges  = 1;
         e.rdata  = last_rdata;
      end else begin
         k = rd ? ((1 + delay) > 2 ? 1 + delay : 2) : ((1 + delay) > 3 ? 1 + delay : 3);
         if (k > 1 + int'(TIMEOUT)) begin
            e.is_err = 1;
            e.edges  = TIMEOUT + 2;
            e.rdata  = last_rdata;
         end else begin
            e.is_err = 0;
            e.edges  = k + 1;
            if (rd) begin
               e.rdata    = ref_mem[a[9:0]];
               last_rdata = e.rdata;
            end else begin
               ref_mem[a[9:0]] = d;
               e.rdata         = last_rdata;
            end
         end
      end
      expq.push_back(e);
      strobe_seen = 0;
      set_req(rd, wr, a, d);
      @(posedge clk);
      #1;
      if (garbage && !bad) begin
         // Requests while busy must be dropped, not queued.
         repeat (2) begin
            set_req(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            @(posedge clk);
            #1;
         end
      end
      set_req(0, 0, 16'h0, 16'h0);
      n = 0;
      while ((expq.size() != 0 || bus.busy) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL no_completion pending=%0d busy=%0b required=0 pending", expq.size(),
                  bus.busy);
         expq.delete();
      end
   endtask

   initial begin
      logic [15:0] a;
      bit          rd;
      bit          wr;
      int          dly;
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = 16'($urandom);
         ref_mem[i] = ram[i];
      end
      ram[5]     = 16'hBEEF;
      ref_mem[5] = 16'hBEEF;
      bus.mem_rdy  = 1'b0;
      bus.mem_dout = 16'h0;
      set_req(0, 0, 16'h0, 16'h0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
      chk("rst_done", {31'd0, bus.cpu_done}, 32'd0);
      chk("rst_err", {31'd0, bus.cpu_err}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_strobes", {30'd0, bus.mem_nd, bus.mem_we}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1, 0, 16'h0005, 16'h0, 0, 0);
      issue(0, 1, 16'h03FF, 16'h1234, 0, 0);
      issue(1, 0, 16'h03FF, 16'h0, 0, 0);
      issue(1, 0, 16'h0400, 16'h0, 0, 0);
      issue(1, 1, 16'h0005, 16'h5555, 0, 0);
      issue(1, 0, 16'h0005, 16'h0, 1, 1);
      issue(0, 1, 16'h0010, 16'hCAFE, 2, 1);
      issue(1, 0, 16'h0010, 16'h0, 0, 1);
      issue(1, 0, 16'h0007, 16'h0, 200, 0);
      issue(0, 1, 16'h0008, 16'hAAAA, 200, 0);
      issue(1, 0, 16'h0009, 16'h0, TIMEOUT, 0);
      issue(1, 0, 16'h000A, 16'h0, TIMEOUT + 1, 0);
      issue(0, 1, 16'h000B, 16'h7777, TIMEOUT, 0);
      issue(1, 0, 16'h000B, 16'h0, 0, 0);

      // Reset while a read is waiting for rdy.
      ram_delay = 6;
      set_req(1, 0, 16'h0005, 16'h0);
      @(posedge clk);
      #1;
      set_req(0, 0, 16'h0, 16'h0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
      chk("mid_nd_before_rst", {31'd0, bus.mem_nd}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_rst_strobes", {30'd0, bus.mem_nd, bus.mem_we}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_pulses", {30'd0, bus.cpu_done, bus.cpu_err}, 32'd0);
      chk("mid_rst_rdata", {16'd0, bus.cpu_rdata}, 32'd0);
      chk("mid_rst_addr", {22'd0, bus.mem_addr}, 32'd0);
      chk("mid_rst_din", {16'd0, bus.mem_din}, 32'd0);
      last_rdata = 16'h0;
      issue(1, 0, 16'h0005, 16'h0, 0, 0);

      for (int t = 0; t < 200; t++) begin
         rd  = 1'($urandom);
         wr  = !rd;
         if ($urandom_range(0, 15) == 0) begin
            rd = 1;
            wr = 1;
         end
         a = 16'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(1024, 65535));
         dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 5))
                                           : int'($urandom_range(0, 4));
         issue(rd, wr, a, 16'($urandom), dly, 1'($urandom));
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
